// File: rtl/l1_icache_2way_pkg.sv
// Shared types and geometry for the 2-way L1 instruction cache.
// Address split (16-bit byte address): tag=[15:7] index=[6:4] offset=[3:0].
package l1_icache_2way_pkg;

    localparam int NUM_SETS    = 8;
    localparam int INDEX_BITS  = 3;
    localparam int OFFSET_BITS = 4;
    localparam int TAG_BITS    = 16 - INDEX_BITS - OFFSET_BITS;

    typedef logic [15:0]            lc3b_word;
    typedef logic [TAG_BITS-1:0]    lc3b_c_tag;
    typedef logic [INDEX_BITS-1:0]  lc3b_c_index;
    typedef logic [OFFSET_BITS-1:0] lc3b_c_offset;
    typedef logic [127:0]           lc3b_datbus;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } icache_state_e;

    // Two byte enables for the 16-bit word selected by address bits [3:1].
    function automatic lc3b_word isel_of(input logic [2:0] word_sel);
        return 16'h0003 << {word_sel, 1'b0};
    endfunction

endpackage

// File: rtl/l1_icache_2way_if.sv
// Bus bundle between the cache and its environment (IF stage on one side,
// physical memory / arbiter on the other).
//   slave  : the cache's view (takes fetches, issues line fills)
//   master : the environment's view (CPU fetch side plus memory side)
//
// Handshakes: icache_read is a level request held with a stable icache_addr
// until icache_resp is seen high on a rising edge; icache_resp is high only in
// cycles where icache_rdata is the requested line. pmem_read is likewise held
// with a stable pmem_address until pmem_resp; pmem_rdata is consumed on the
// rising edge where pmem_resp is high, and pmem_resp outside a fill is ignored.
interface l1_icache_2way_if;
    import l1_icache_2way_pkg::*;

    lc3b_word   icache_addr;
    logic       icache_read;
    logic       icache_resp;
    lc3b_datbus icache_rdata;
    lc3b_word   isel_mask;
    lc3b_word   pmem_address;
    logic       pmem_read;
    logic       pmem_resp;
    lc3b_datbus pmem_rdata;

    modport slave (
        input  icache_addr, icache_read, pmem_resp, pmem_rdata,
        output icache_resp, icache_rdata, isel_mask, pmem_address, pmem_read
    );

    modport master (
        output icache_addr, icache_read, pmem_resp, pmem_rdata,
        input  icache_resp, icache_rdata, isel_mask, pmem_address, pmem_read
    );

endinterface

// File: rtl/l1_icache_2way_way_array.sv
// One way of the cache: per-set data line, tag and valid bit.
// Ports: clk, reset (async, clears valid bits only), combinational read
// port (rd_index -> rd_valid/rd_tag/rd_data), single write port
// (wr_en/wr_index/wr_tag/wr_data) that also marks the set valid.
module l1_icache_2way_way_array
    import l1_icache_2way_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  lc3b_c_index rd_index,
    output logic        rd_valid,
    output lc3b_c_tag   rd_tag,
    output lc3b_datbus  rd_data,
    input  logic        wr_en,
    input  lc3b_c_index wr_index,
    input  lc3b_c_tag   wr_tag,
    input  lc3b_datbus  wr_data
);

    logic [NUM_SETS-1:0] valid_q;
    lc3b_c_tag           tag_mem  [NUM_SETS];
    lc3b_datbus          data_mem [NUM_SETS];

    // Only valid bits need reset; stale tag/data behind a clear valid bit is harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/l1_icache_2way.sv
// Read-only 2-way set-associative L1 instruction cache.
// Ports: clk, reset (async active-high), bus (slave modport: fetch request/
// response, byte-select mask, line-fill request/response), hit_count and
// miss_count (wrapping 16-bit event counters), state_dbg (FSM state).
// Hits respond in the same cycle; a miss moves to FILL, holds pmem_read until
// pmem_resp, installs the line, and the still-held request then hits in IDLE.
module l1_icache_2way
    import l1_icache_2way_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    l1_icache_2way_if.slave       bus,
    output lc3b_word              hit_count,
    output lc3b_word              miss_count,
    output icache_state_e         state_dbg
);

    icache_state_e state, next_state;

    lc3b_c_tag   req_tag;
    lc3b_c_index req_index;
    logic        unused_addr_bit;

    logic        way_valid [2];
    lc3b_c_tag   way_tag   [2];
    lc3b_datbus  way_data  [2];
    logic        way_wr    [2];

    logic [NUM_SETS-1:0] lru_q;     // per set: the way to evict next
    lc3b_c_tag           fill_tag;
    lc3b_c_index         fill_index;
    logic                fill_way;

    logic hit_w0, hit_w1, lookup_hit, miss_start, fill_done, victim;

    assign req_tag         = bus.icache_addr[15:7];
    assign req_index       = bus.icache_addr[6:4];
    assign unused_addr_bit = bus.icache_addr[0];

    for (genvar w = 0; w < 2; w++) begin : g_way
        l1_icache_2way_way_array u_way (
            .clk      (clk),
            .reset    (reset),
            .rd_index (req_index),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w]),
            .wr_en    (way_wr[w]),
            .wr_index (fill_index),
            .wr_tag   (fill_tag),
            .wr_data  (bus.pmem_rdata)
        );
    end

    // Lookups only count in IDLE so a request held through FILL never responds early.
    assign hit_w0     = way_valid[0] && (way_tag[0] == req_tag);
    assign hit_w1     = way_valid[1] && (way_tag[1] == req_tag);
    assign lookup_hit = (state == S_IDLE) && bus.icache_read && (hit_w0 || hit_w1);
    assign miss_start = (state == S_IDLE) && bus.icache_read && !(hit_w0 || hit_w1);
    assign fill_done  = (state == S_FILL) && bus.pmem_resp;

    assign way_wr[0] = fill_done && (fill_way == 1'b0);
    assign way_wr[1] = fill_done && (fill_way == 1'b1);

    // Invalid ways are filled first (way0 before way1), otherwise follow LRU.
    assign victim = !way_valid[0] ? 1'b0 :
                    !way_valid[1] ? 1'b1 : lru_q[req_index];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (miss_start) next_state = S_FILL;
            S_FILL: if (bus.pmem_resp) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lru_q      <= '0;
            fill_tag   <= '0;
            fill_index <= '0;
            fill_way   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (lookup_hit) begin
                // Evict the way that was not just used: way0 hit -> lru=1.
                lru_q[req_index] <= hit_w0;
                hit_count        <= hit_count + 16'd1;
            end
            if (miss_start) begin
                fill_tag   <= req_tag;
                fill_index <= req_index;
                fill_way   <= victim;
                miss_count <= miss_count + 16'd1;
            end
            if (fill_done) begin
                lru_q[fill_index] <= ~fill_way;
            end
        end
    end

    assign bus.icache_resp  = lookup_hit;
    assign bus.icache_rdata = !lookup_hit ? '0 : (hit_w0 ? way_data[0] : way_data[1]);
    assign bus.isel_mask    = isel_of(bus.icache_addr[3:1]);
    assign bus.pmem_read    = (state == S_FILL);
    assign bus.pmem_address = {fill_tag, fill_index, 4'h0};
    assign state_dbg        = state;

endmodule

// File: tb/tb_l1_icache_2way.sv
// Directed bench for l1_icache_2way: cold miss/fill, same-line hit, LRU
// eviction, redirect during fill, stray pmem_resp, reset mid-fill, counter wrap,
// byte-select table.
module tb_l1_icache_2way;
    import l1_icache_2way_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l1_icache_2way_if bus();
    lc3b_word      hit_count, miss_count;
    icache_state_e state_dbg;

    l1_icache_2way dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    lc3b_word     exp_hits   = '0;
    lc3b_word     exp_misses = '0;
    int           n_tests    = 0;
    int           n_fail     = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Distinct, recognisable line contents per line address.
    function automatic logic [127:0] line_for(input lc3b_word a);
        return {8{a[15:4], 4'hA}} ^ {16{8'h3C}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"},   128'(hit_count),  128'(exp_hits));
        check({tag, "_misses"}, 128'(miss_count), 128'(exp_misses));
    endtask

    // Expected hit: response in the same cycle, no fill traffic.
    task automatic read_hit(input lc3b_word a, input string tag);
        logic [127:0] exp_line;
        exp_q.push_back(line_for(a));
        bus.icache_addr = a;
        bus.icache_read = 1'b1;
        @(negedge clk);
        exp_line = exp_q.pop_front();
        check({tag, "_resp"},  128'(bus.icache_resp), 128'(1'b1));
        check({tag, "_rdata"}, bus.icache_rdata, exp_line);
        check({tag, "_nopmem"}, 128'(bus.pmem_read), 128'(1'b0));
        tick();
        exp_hits++;
        bus.icache_read = 1'b0;
        check_counters(tag);
    endtask

    // Expected miss: fill runs, then the held request hits the cycle after pmem_resp.
    task automatic read_miss(input lc3b_word a, input string tag);
        int n;
        logic [127:0] exp_line;
        bus.icache_addr = a;
        bus.icache_read = 1'b1;
        @(negedge clk);
        check({tag, "_noresp"}, 128'(bus.icache_resp), 128'(1'b0));
        tick();
        exp_misses++;
        n = 0;
        while (!bus.pmem_read && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_pmem_read"}, 128'(bus.pmem_read), 128'(1'b1));
        check({tag, "_pmem_addr"}, 128'(bus.pmem_address), 128'({a[15:4], 4'h0}));
        check({tag, "_state"}, 128'(state_dbg), 128'(S_FILL));
        exp_q.push_back(line_for(a));
        bus.pmem_rdata = line_for(a);
        bus.pmem_resp  = 1'b1;
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        @(negedge clk);
        exp_line = exp_q.pop_front();
        check({tag, "_retry_resp"},  128'(bus.icache_resp), 128'(1'b1));
        check({tag, "_retry_rdata"}, bus.icache_rdata, exp_line);
        tick();
        exp_hits++;   // the retry is a normal hit
        bus.icache_read = 1'b0;
        check_counters(tag);
    endtask

    // ---------------- stimulus ----------------
    lc3b_word isel_tab [8] = '{16'h0003, 16'h000C, 16'h0030, 16'h00C0,
                               16'h0300, 16'h0C00, 16'h3000, 16'hC000};

    initial begin
        bus.icache_addr = '0;
        bus.icache_read = 1'b0;
        bus.pmem_resp   = 1'b0;
        bus.pmem_rdata  = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_resp",  128'(bus.icache_resp), 128'(1'b0));
        check("rst_pmem",  128'(bus.pmem_read),   128'(1'b0));
        check("rst_state", 128'(state_dbg),       128'(S_IDLE));
        check_counters("rst");

        // Cold miss on 0x0042 (idx 4, word 1).
        bus.icache_addr = 16'h0042;
        #1 check("cold_isel", 128'(bus.isel_mask), 128'(16'h000C));
        read_miss(16'h0042, "cold");

        // Same line, last word.
        bus.icache_addr = 16'h004E;
        #1 check("hit_isel", 128'(bus.isel_mask), 128'(16'hC000));
        read_hit(16'h004E, "hit");

        // LRU: 0x0040 in way0. 0x00C0 fills way1, touch 0x0040, 0x0140 evicts 0x00C0.
        read_miss(16'h00C0, "lru_fill_b");
        read_hit(16'h0040, "lru_touch_a");
        read_miss(16'h0140, "lru_fill_c");
        read_hit(16'h0040, "lru_keep_a");
        read_miss(16'h00C0, "lru_evicted_b");

        // Redirect: miss on 0x0200, new address shown then request dropped mid-fill.
        bus.icache_addr = 16'h0200;
        bus.icache_read = 1'b1;
        tick();
        exp_misses++;
        check("redir_pmem_addr", 128'(bus.pmem_address), 128'(16'h0200));
        bus.icache_addr = 16'h0042;   // resident line, but FILL must not answer
        @(negedge clk);
        check("redir_fill_noresp", 128'(bus.icache_resp), 128'(1'b0));
        tick();
        bus.icache_read = 1'b0;
        check("redir_still_fill", 128'(state_dbg), 128'(S_FILL));
        bus.pmem_rdata = line_for(16'h0200);
        bus.pmem_resp  = 1'b1;
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        @(negedge clk);
        check("redir_idle_noresp", 128'(bus.icache_resp), 128'(1'b0));
        check("redir_idle_state",  128'(state_dbg),       128'(S_IDLE));
        check_counters("redir");

        // Stray pmem_resp in IDLE is ignored.
        bus.pmem_rdata = '1;
        bus.pmem_resp  = 1'b1;
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        check("stray_state", 128'(state_dbg), 128'(S_IDLE));
        read_hit(16'h0200, "redir_hit");

        // Reset in the middle of a fill.
        bus.icache_addr = 16'h0300;
        bus.icache_read = 1'b1;
        tick();
        check("rstfill_pmem_up", 128'(bus.pmem_read), 128'(1'b1));
        #2 reset = 1'b1;
        #1;
        check("rstfill_pmem_drop", 128'(bus.pmem_read), 128'(1'b0));
        check("rstfill_state",     128'(state_dbg),     128'(S_IDLE));
        exp_hits   = '0;
        exp_misses = '0;
        exp_q.delete();
        check_counters("rstfill");
        bus.icache_read = 1'b0;
        tick();
        reset = 1'b0;
        read_miss(16'h004E, "post_rst_a");
        read_miss(16'h0200, "post_rst_b");

        // Wrap: hold a hitting request until hit_count passes 0xFFFF.
        bus.icache_addr = 16'h004E;
        bus.icache_read = 1'b1;
        for (int i = 0; i < 16'hFFFF - exp_hits; i++) tick();
        check("wrap_max", 128'(hit_count), 128'(16'hFFFF));
        tick();
        check("wrap_zero", 128'(hit_count), 128'(16'h0000));
        check("wrap_misses", 128'(miss_count), 128'(16'd2));
        bus.icache_read = 1'b0;

        // Byte-select table for every word in a line.
        for (int i = 0; i < 8; i++) begin
            bus.icache_addr = 16'h1230 | lc3b_word'(2 * i);
            #1 check("isel_tab", 128'(bus.isel_mask), 128'(isel_tab[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
